// File: rtl/blink_meter_if.sv
// Measurement bus for blink_meter: the sampled input and everything the meter reports.
// The master side drives sig_in; the slave side (the meter) drives all results.
interface blink_meter_if;
  logic        sig_in;
  logic        level;
  logic [31:0] half_period;
  logic        valid;
  logic        in_range;
  logic        stalled;
  logic [15:0] edge_count;

  modport master (
    output sig_in,
    input  level, half_period, valid, in_range, stalled, edge_count
  );

  modport slave (
    input  sig_in,
    output level, half_period, valid, in_range, stalled, edge_count
  );
endinterface

// File: rtl/blink_meter.sv
// Half-period meter for an asynchronous square wave with range check and stall detection.
// Optional glitch filter: define BLINK_METER_GLITCH_FILTER_EN to ignore edges closer than MIN_CYCLES.
module blink_meter #(
  parameter int unsigned TIMEOUT_CYCLES  = 50000000,
  parameter int unsigned EXPECTED_CYCLES = 25000001,
  parameter int unsigned TOL_CYCLES      = 1000,
  parameter int unsigned MIN_CYCLES      = 16
) (
  input  logic          clk,
  input  logic          rst,
  blink_meter_if.slave  io_mtr
);

`ifdef BLINK_METER_GLITCH_FILTER_EN
  localparam bit LP_FILTER_EN = 1'b1;
`else
  localparam bit LP_FILTER_EN = 1'b0;
`endif

  // Lower window bound clamps at zero instead of wrapping when TOL exceeds EXPECTED.
  localparam logic [32:0] LP_LO = (EXPECTED_CYCLES >= TOL_CYCLES) ?
                                  33'(EXPECTED_CYCLES - TOL_CYCLES) : 33'd0;
  localparam logic [32:0] LP_HI = 33'(EXPECTED_CYCLES) + 33'(TOL_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_STALLED
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [31:0] r_counter;
  logic [31:0] r_half_period;
  logic        r_valid;
  logic        r_in_range;
  logic        r_stalled;
  logic [15:0] r_edge_count;

  logic        w_edge;
  logic        w_min_ok;
  logic        w_accept;
  logic        w_in_window;
  logic        w_timeout;
  logic [31:0] w_counter_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= io_mtr.sig_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge        = r_sync2 ^ r_prev;
  assign w_min_ok      = !LP_FILTER_EN || (r_counter >= 32'(MIN_CYCLES));
  assign w_accept      = w_edge && w_min_ok;
  assign w_in_window   = ({1'b0, r_counter} >= LP_LO) && ({1'b0, r_counter} <= LP_HI);
  assign w_timeout     = (r_counter == 32'(TIMEOUT_CYCLES));
  assign w_counter_inc = (r_counter == 32'hFFFF_FFFF) ? r_counter : r_counter + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_counter     <= 32'd0;
      r_half_period <= 32'd0;
      r_valid       <= 1'b0;
      r_in_range    <= 1'b0;
      r_stalled     <= 1'b0;
      r_edge_count  <= 16'd0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        // No interval is known yet, so the first edge only starts timing.
        ST_IDLE, ST_STALLED: begin
          if (w_edge) begin
            r_state      <= ST_MEASURE;
            r_counter    <= 32'd1;
            r_edge_count <= r_edge_count + 16'd1;
            r_stalled    <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (w_accept) begin
            r_half_period <= r_counter;
            r_valid       <= 1'b1;
            r_in_range    <= w_in_window;
            r_counter     <= 32'd1;
            r_edge_count  <= r_edge_count + 16'd1;
          end else if (w_timeout) begin
            r_state    <= ST_STALLED;
            r_stalled  <= 1'b1;
            r_in_range <= 1'b0;
          end else begin
            r_counter <= w_counter_inc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_mtr.level       = r_sync2;
  assign io_mtr.half_period = r_half_period;
  assign io_mtr.valid       = r_valid;
  assign io_mtr.in_range    = r_in_range;
  assign io_mtr.stalled     = r_stalled;
  assign io_mtr.edge_count  = r_edge_count;

endmodule

// File: tb/tb_blink_meter.sv
// Randomized and directed stimulus for blink_meter, checked every cycle against a
// timestamp-based reference model of accepted edges.
module tb_blink_meter;
  localparam int TO   = 100;
  localparam int EXPC = 20;
  localparam int TOL  = 2;
  localparam int MINC = 4;
`ifdef BLINK_METER_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  blink_meter_if mtr ();

  blink_meter #(
    .TIMEOUT_CYCLES (TO),
    .EXPECTED_CYCLES(EXPC),
    .TOL_CYCLES     (TOL),
    .MIN_CYCLES     (MINC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_mtr(mtr)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: sig_in samples per clock, timestamps of accepted edges.
  bit          smp[$];
  longint      cyc;
  longint      m_last;
  bit          m_active;
  bit          e_valid;
  logic [31:0] e_hp;
  bit          e_inr;
  bit          e_stl;
  bit [15:0]   e_cnt;

  task automatic model_reset();
    smp      = '{1'b0, 1'b0, 1'b0, 1'b0};
    m_active = 1'b0;
    e_valid  = 1'b0;
    e_hp     = 32'd0;
    e_inr    = 1'b0;
    e_stl    = 1'b0;
    e_cnt    = 16'd0;
  endtask

  task automatic step();
    bit     d;
    bit     acc;
    longint iv;
    @(posedge clk);
    cyc++;
    smp.push_front(mtr.sig_in);
    void'(smp.pop_back());
    // The level seen by the meter lags sig_in by two samples; an edge is a change in it.
    d       = (smp[2] != smp[3]);
    acc     = 1'b0;
    e_valid = 1'b0;
    if (d) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_last   = cyc;
        e_stl    = 1'b0;
        e_cnt++;
        acc = 1'b1;
      end else begin
        iv = cyc - m_last;
        if (!(FILT && iv < MINC)) begin
          e_valid = 1'b1;
          e_hp    = 32'(iv);
          e_inr   = (iv >= EXPC - TOL) && (iv <= EXPC + TOL);
          m_last  = cyc;
          e_cnt++;
          acc = 1'b1;
        end
      end
    end
    if (m_active && !acc && (cyc - m_last == TO)) begin
      m_active = 1'b0;
      e_stl    = 1'b1;
      e_inr    = 1'b0;
    end
    @(negedge clk);
    chk("level",       32'(mtr.level),      32'(smp[1]));
    chk("valid",       32'(mtr.valid),      32'(e_valid));
    chk("half_period", mtr.half_period,     e_hp);
    chk("in_range",    32'(mtr.in_range),   32'(e_inr));
    chk("stalled",     32'(mtr.stalled),    32'(e_stl));
    chk("edge_count",  32'(mtr.edge_count), 32'(e_cnt));
  endtask

  task automatic toggle_then(input int gap);
    mtr.sig_in = ~mtr.sig_in;
    repeat (gap) step();
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_level"},      32'(mtr.level),      32'd0);
    chk({pfx, "_hp"},         mtr.half_period,     32'd0);
    chk({pfx, "_valid"},      32'(mtr.valid),      32'd0);
    chk({pfx, "_in_range"},   32'(mtr.in_range),   32'd0);
    chk({pfx, "_stalled"},    32'(mtr.stalled),    32'd0);
    chk({pfx, "_edge_count"}, 32'(mtr.edge_count), 32'd0);
  endtask

  task automatic do_reset(input string pfx);
    rst = 1'b1;
    #1;
    check_zero(pfx);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int gap;
    mtr.sig_in = 1'b0;
    cyc        = 0;
    m_last     = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    repeat (8) toggle_then(20);
    chk("square_hp", mtr.half_period, 32'd20);
    chk("square_inr", 32'(mtr.in_range), 32'd1);

    toggle_then(23);
    toggle_then(23);
    chk("slow_hp", mtr.half_period, 32'd23);
    chk("slow_inr", 32'(mtr.in_range), 32'd0);
    toggle_then(18);
    toggle_then(18);
    chk("fast_hp", mtr.half_period, 32'd18);
    chk("fast_inr", 32'(mtr.in_range), 32'd1);

    toggle_then(120);
    chk("stall_set", 32'(mtr.stalled), 32'd1);
    toggle_then(20);
    chk("stall_clear", 32'(mtr.stalled), 32'd0);
    toggle_then(20);
    chk("after_stall_hp", mtr.half_period, 32'd20);

    // Two-cycle pulse right after a real edge.
    toggle_then(1);
    toggle_then(2);
    toggle_then(17);
    toggle_then(20);
    chk("glitch_hp", mtr.half_period, FILT ? 32'd20 : 32'd17);

    mtr.sig_in = ~mtr.sig_in;
    repeat (12) step();
    do_reset("midrst");
    repeat (3) toggle_then(20);

    repeat (60) begin
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(95, 110))
                                        : int'($urandom_range(1, 30));
      toggle_then(gap);
    end

    mtr.sig_in = 1'b0;
    repeat (3) step();
    do_reset("wraprst");
`ifdef BLINK_METER_GLITCH_FILTER_EN
    repeat (300) toggle_then(MINC);
    repeat (3) step();
    chk("many_edges", 32'(mtr.edge_count), 32'd300);
`else
    repeat (65537) toggle_then(1);
    repeat (3) step();
    chk("wrap", 32'(mtr.edge_count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/blink_meter.md
BLINK_METER -- requirements
Module: blink_meter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 50000000, the cycle count without an edge after which the input is declared stalled.
REQ-002 The module SHALL have parameter EXPECTED_CYCLES, default 25000001, the nominal half-period in clk cycles.
REQ-003 The module SHALL have parameter TOL_CYCLES, default 1000, the allowed deviation from EXPECTED_CYCLES, inclusive.
REQ-004 The module SHALL have parameter MIN_CYCLES, default 16, the minimum accepted edge spacing; it is used only with the glitch filter.
REQ-005 clk  input  1  single clock, 50 MHz.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 sig_in  input  1  asynchronous square-wave input under measurement, e.g. an LED drive line.
REQ-008 level  output  1  synchronized copy of sig_in.
REQ-009 half_period  output  32  cycles between the last two accepted edges.
REQ-010 valid  output  1  one-cycle strobe marking a new half_period.
REQ-011 in_range  output  1  last half_period is within EXPECTED_CYCLES±TOL_CYCLES.
REQ-012 stalled  output  1  no accepted edge for TIMEOUT_CYCLES cycles.
REQ-013 edge_count  output  16  accepted edges since reset; wraps from 0xFFFF to 0.

Function
REQ-014 sig_in SHALL pass through a 2-flop synchronizer; a third flop holds the previous synchronized value, and edge = sync XOR prev (both polarities).
REQ-015 level SHALL equal the synchronized value, 2 cycles after sig_in changes.
REQ-016 The FSM SHALL have three states: IDLE, MEASURE and STALLED.
REQ-017 IDLE -> MEASURE SHALL occur on the first accepted edge: counter=1, edge_count+1, no valid.
REQ-018 MEASURE, no edge: counter SHALL increment by 1 per cycle and saturate at 0xFFFFFFFF.
REQ-019 MEASURE, accepted edge: half_period SHALL load counter, then valid=1 for exactly one cycle, in_range updates, counter=1 and edge_count+1; valid, half_period and in_range update on the same clock edge.
REQ-020 Edges at strobe cycles t0 and t1 SHALL yield half_period = t1-t0.
REQ-021 in_range SHALL be 1 iff EXPECTED_CYCLES-TOL_CYCLES <= counter <= EXPECTED_CYCLES+TOL_CYCLES, with unsigned 33-bit compare and no wrap on the subtraction.
REQ-022 MEASURE, when counter == TIMEOUT_CYCLES with no edge in that cycle: the FSM SHALL go to STALLED with stalled=1 and in_range=0; half_period is retained and valid is not asserted.
REQ-023 STALLED, accepted edge: the FSM SHALL go to MEASURE with stalled=0, counter=1 and edge_count+1; no valid is issued, since the interval is unknown.
REQ-024 An edge in the same cycle as the timeout condition SHALL take priority: it is processed as REQ-019 and there is no stall.
REQ-025 The total latency SHALL be: a sig_in transition sampled at clk edge k produces valid high in the cycle after edge k+2.

Reset
REQ-026 While rst is high, all flops SHALL clear asynchronously: state=IDLE, counter=0, half_period=0, valid=0, in_range=0, stalled=0, edge_count=0, level=0, synchronizer=0.
REQ-027 After rst deasserts, the first synchronized 1 SHALL be treated as an edge; reset mid-measurement discards the partial interval.

Configuration
REQ-028 The macro BLINK_METER_GLITCH_FILTER_EN SHALL control the glitch filter as follows.
- Defined: in MEASURE, an edge with counter < MIN_CYCLES is ignored. There is no half_period, valid or edge_count change, and counter keeps incrementing.
- Undefined: every edge is accepted and MIN_CYCLES has no effect.
- The port list is identical in both builds.

Verification (TIMEOUT_CYCLES=100, EXPECTED_CYCLES=20, TOL_CYCLES=2, MIN_CYCLES=4)
REQ-029 Square wave toggling every 20 cycles -> from the second edge on, valid every 20 cycles, half_period=20, in_range=1, edge_count increments per toggle.
REQ-030 Toggle spacing 23 -> half_period=23, in_range=0; spacing 18 -> in_range=1.
REQ-031 Hold sig_in constant 100 cycles after an edge -> stalled=1 at counter=100, no valid; next toggle -> stalled=0, no valid; following toggle 20 later -> valid with half_period=20.
REQ-032 Filter defined: pulse 2 cycles wide within a 20-cycle wave -> both glitch edges ignored, next half_period=20. Filter undefined: the same stimulus gives half_period=2 and valid pulses for each glitch edge.
REQ-033 Assert rst mid-interval (counter=10) -> all outputs 0 immediately; the first post-reset edge gives no valid.
REQ-034 Drive 65537 accepted edges -> edge_count wraps to 1.
